nibbler_fetch_decode: RTL

- Upstream control stage of the Nibbler 4-bit CPU.
- Sequences instruction fetch from the 4K x 8 program ROM, holds the 12-bit program counter and instruction register, and resolves jumps.
- Drives the ALU control pins (func, mode, carryIn), the immediate B operand, and the write enables for the accumulator/flag register stage downstream of the ALU.
- Uses a two-phase fetch/execute FSM: every instruction takes 2 cycles.

---
 rtl/nibbler_fetch_decode.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nibbler_fetch_decode.sv
// nibbler_fetch_decode
//   Fetch/decode control stage of the Nibbler 4-bit CPU. It holds the 12-bit
//   program counter and the 8-bit instruction register, and alternates between
//   two phases for every instruction:
//   - FETCH: latch the instruction byte.
//   - EXEC: decode it and drive the ALU controls and the write strobes, or
//     resolve a jump.
//   An HLT instruction parks the block in HALT. Only reset leaves HALT.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   instr_data_i   ROM read data (combinational from rom_addr_o)
//   carry_flag_i   registered carry flag
//   zero_flag_i    registered zero flag
//   rom_addr_o     ROM address (= PC)
//   alu_func_o     74181 S3..S0
//   alu_mode_o     74181 M (1 = logic)
//   alu_cin_o      74181 Cn, low-true (1 = no carry)
//   imm_out_o      immediate nibble to the ALU B port
//   acc_we_o       accumulator write enable
//   flag_we_o      carry/zero flag write enable
//   out_we_o       output-port write strobe
//   phase_o        0 = FETCH, 1 = EXEC
//   halted_o       high in HALT
//
// state | meaning
// FETCH | latch IR from ROM, PC <= PC+1
// EXEC  | decode IR, strobe enables, resolve jumps
// HALT  | frozen until reset
module nibbler_fetch_decode #(
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  instr_data_i,
  input  logic        carry_flag_i,
  input  logic        zero_flag_i,
  output logic [11:0] rom_addr_o,
  output logic [3:0]  alu_func_o,
  output logic        alu_mode_o,
  output logic        alu_cin_o,
  output logic [3:0]  imm_out_o,
  output logic        acc_we_o,
  output logic        flag_we_o,
  output logic        out_we_o,
  output logic        phase_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_OUT   = 4'h9;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;

  logic [3:0]  opcode;
  logic [3:0]  imm;
  logic [11:0] pc_inc;
  logic [11:0] jump_target;

  assign opcode      = ir_q[7:4];
  assign imm         = ir_q[3:0];
  assign pc_inc      = pc_q + 12'd1;  // 12-bit wrap is intentional
  // During EXEC the PC already points at the jump's second byte.
  assign jump_target = {imm, instr_data_i};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instr_data_i;
        pc_d    = pc_inc;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_JMP:  pc_d = jump_target;
          // A jump that is not taken still has to step over its second byte.
          OP_JC:   pc_d = carry_flag_i ? jump_target : pc_inc;
          OP_JZ:   pc_d = zero_flag_i ? jump_target : pc_inc;
          OP_HLT:  state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // The decode depends only on registered state and IR, so the outputs are
  // steady for the whole cycle. Outside EXEC they stay at the ALU idle values.
  always_comb begin
    alu_func_o = 4'b0000;
    alu_mode_o = 1'b0;
    alu_cin_o  = 1'b1;
    imm_out_o  = 4'h0;
    acc_we_o   = 1'b0;
    flag_we_o  = 1'b0;
    out_we_o   = 1'b0;
    if (state_q == ST_EXEC) begin
      case (opcode)
        OP_LDI: begin
          alu_func_o = 4'b1010;
          alu_mode_o = 1'b1;
          imm_out_o  = imm;
          acc_we_o   = 1'b1;
          flag_we_o  = 1'b1;
        end
        OP_ADDI: begin
          alu_func_o = 4'b1001;
          imm_out_o  = imm;
          acc_we_o   = 1'b1;
          flag_we_o  = 1'b1;
        end
        OP_SUBI: begin
          alu_func_o = 4'b0110;
          alu_cin_o  = 1'b0;
          imm_out_o  = imm;
          acc_we_o   = 1'b1;
          flag_we_o  = 1'b1;
        end
        OP_NANDI: begin
          alu_func_o = 4'b0100;
          alu_mode_o = 1'b1;
          imm_out_o  = imm;
          acc_we_o   = 1'b1;
          flag_we_o  = 1'b1;
        end
        OP_CMPI: begin
          alu_func_o = 4'b0110;
          alu_cin_o  = 1'b0;
          imm_out_o  = imm;
          flag_we_o  = 1'b1;
        end
        OP_OUT:  out_we_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign rom_addr_o = pc_q;
  assign phase_o    = (state_q == ST_EXEC);
  assign halted_o   = (state_q == ST_HALT);

endmodule
